// File: rtl/fb_scan_ctrl.sv
// Framebuffer sequencer: 800x600@60 scan timing with a 2-stage read/display pipeline,
// plus a frame-gated write path from the Mandelbrot pixel stream into the framebuffer.
module fb_scan_ctrl #(
    parameter int H_VIS     = 400,
    parameter int H_FP      = 20,
    parameter int H_SYNC    = 64,
    parameter int H_BP      = 44,
    parameter int V_VIS     = 600,
    parameter int V_FP      = 1,
    parameter int V_SYNC    = 4,
    parameter int V_BP      = 23,
    parameter bit SYNC_POL  = 1'b1,
    parameter int FB_PIXELS = 120000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_valid,
    input  logic [3:0] pix_data,
    input  logic       pix_frame_start,
    input  logic       wr_en,
    output logic       fb_read,
    output logic       fb_reset_read_ptr,
    output logic       fb_write,
    output logic [3:0] fb_wdata,
    output logic       fb_reset_write_ptr,
    output logic       de,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_done,
    output logic       proto_err
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int CW      = $clog2(FB_PIXELS + 1);

    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS_L   = HW'(H_VIS);
    localparam logic [HW-1:0] HS_START  = HW'(H_VIS + H_FP);
    localparam logic [HW-1:0] HS_END    = HW'(H_VIS + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS_L   = VW'(V_VIS);
    localparam logic [VW-1:0] VS_START  = VW'(V_VIS + V_FP);
    localparam logic [VW-1:0] VS_END    = VW'(V_VIS + V_FP + V_SYNC);
    localparam logic [CW-1:0] WCNT_LAST = CW'(FB_PIXELS - 1);

    typedef enum logic [1:0] {
        W_IDLE,
        W_FILL,
        W_FULL
    } wstate_t;

    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic          hs_s1;
    logic          vs_s1;

    wstate_t       state;
    wstate_t       state_n;
    logic [CW-1:0] wcnt;
    logic [CW-1:0] wcnt_n;
    logic          accept;
    logic          write_n;
    logic          wrst_n;
    logic          done_n;
    logic          err_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            h <= '0;
            v <= '0;
        end else if (h == H_LAST) begin
            h <= '0;
            v <= (v == V_LAST) ? '0 : v + VW'(1);
        end else begin
            h <= h + HW'(1);
        end
    end

    // Stage 1 drives the framebuffer; sync windows are decoded here and only delayed in stage 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            fb_read           <= 1'b0;
            fb_reset_read_ptr <= 1'b1;
            hs_s1             <= 1'b0;
            vs_s1             <= 1'b0;
        end else begin
            fb_read           <= (h < H_VIS_L) && (v < V_VIS_L);
            fb_reset_read_ptr <= (v >= V_VIS_L);
            hs_s1             <= (h >= HS_START) && (h < HS_END);
            vs_s1             <= (v >= VS_START) && (v < VS_END);
        end
    end

    // Stage 2 lines de up with the pixel the framebuffer returns one clock after fb_read.
    always_ff @(posedge clk) begin
        if (rst) begin
            de    <= 1'b0;
            hsync <= ~SYNC_POL;
            vsync <= ~SYNC_POL;
        end else begin
            de    <= fb_read;
            hsync <= hs_s1 ? SYNC_POL : ~SYNC_POL;
            vsync <= vs_s1 ? SYNC_POL : ~SYNC_POL;
        end
    end

    // A frame start restarts an ongoing fill even with wr_en low; only idle/full states honour wr_en.
    assign accept = pix_frame_start && (wr_en || (state == W_FILL));

    always_comb begin
        state_n = state;
        wcnt_n  = wcnt;
        write_n = 1'b0;
        wrst_n  = 1'b0;
        done_n  = frame_done;
        err_n   = proto_err;
        if (accept) begin
            state_n = W_FILL;
            wcnt_n  = '0;
            wrst_n  = 1'b1;
            done_n  = 1'b0;
            if (pix_valid) begin
                err_n = 1'b1;
            end
        end else if (pix_valid) begin
            case (state)
                W_FILL: begin
                    write_n = 1'b1;
                    wcnt_n  = wcnt + CW'(1);
                    if (wcnt == WCNT_LAST) begin
                        state_n = W_FULL;
                        done_n  = 1'b1;
                    end
                end
                W_FULL: begin
                    err_n = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= W_IDLE;
            wcnt               <= '0;
            fb_write           <= 1'b0;
            fb_reset_write_ptr <= 1'b1;
            fb_wdata           <= 4'd0;
            frame_done         <= 1'b0;
            proto_err          <= 1'b0;
        end else begin
            state              <= state_n;
            wcnt               <= wcnt_n;
            fb_write           <= write_n;
            fb_reset_write_ptr <= wrst_n;
            fb_wdata           <= pix_data;
            frame_done         <= done_n;
            proto_err          <= err_n;
        end
    end

endmodule

// File: tb/tb_fb_scan_ctrl.sv
// Self-checking bench for fb_scan_ctrl on a scaled-down raster, compared every clock
// against a cycle-count based model of the scan timing and a frame/pixel-count write model.
module tb_fb_scan_ctrl;

    localparam int H_VIS     = 40;
    localparam int H_FP      = 4;
    localparam int H_SYNC    = 8;
    localparam int H_BP      = 6;
    localparam int V_VIS     = 30;
    localparam int V_FP      = 1;
    localparam int V_SYNC    = 4;
    localparam int V_BP      = 3;
    localparam bit SYNC_POL  = 1'b1;
    localparam int FB_PIXELS = 600;
    localparam int H_TOTAL   = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL   = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int FRAME     = H_TOTAL * V_TOTAL;

    logic       clk = 1'b0;
    logic       rst;
    logic       pix_valid;
    logic [3:0] pix_data;
    logic       pix_frame_start;
    logic       wr_en;
    logic       fb_read;
    logic       fb_reset_read_ptr;
    logic       fb_write;
    logic [3:0] fb_wdata;
    logic       fb_reset_write_ptr;
    logic       de;
    logic       hsync;
    logic       vsync;
    logic       frame_done;
    logic       proto_err;

    always #5 clk = ~clk;

    fb_scan_ctrl #(
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .SYNC_POL(SYNC_POL), .FB_PIXELS(FB_PIXELS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pix_valid(pix_valid),
        .pix_data(pix_data),
        .pix_frame_start(pix_frame_start),
        .wr_en(wr_en),
        .fb_read(fb_read),
        .fb_reset_read_ptr(fb_reset_read_ptr),
        .fb_write(fb_write),
        .fb_wdata(fb_wdata),
        .fb_reset_write_ptr(fb_reset_write_ptr),
        .de(de),
        .hsync(hsync),
        .vsync(vsync),
        .frame_done(frame_done),
        .proto_err(proto_err)
    );

    int checks = 0;
    int passed = 0;

    // Model: n = clock edges since the last reset edge, i.e. the raster position index.
    int         n = 0;
    bit         m_active = 1'b0;
    int         m_count = 0;
    bit         m_done = 1'b0;
    bit         m_err = 1'b0;
    bit         e_write = 1'b0;
    bit         e_wrst = 1'b1;
    logic [3:0] e_wdata = 4'd0;

    int cnt_read, cnt_de, cnt_hs, cnt_vs, cnt_wr, cnt_wrst;

    function automatic int hpos(int s);
        return s % H_TOTAL;
    endfunction

    function automatic int vpos(int s);
        return (s / H_TOTAL) % V_TOTAL;
    endfunction

    function automatic bit vis_at(int s);
        return (hpos(s) < H_VIS) && (vpos(s) < V_VIS);
    endfunction

    function automatic logic sync_lvl(bit on);
        return on ? SYNC_POL : ~SYNC_POL;
    endfunction

    task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) passed++;
        else $error("[TB] FAIL %s: observed %0h expected %0h (cycle index %0d)", tag, observed, expected, n);
    endtask

    task automatic clear_counts();
        cnt_read = 0;
        cnt_de   = 0;
        cnt_hs   = 0;
        cnt_vs   = 0;
        cnt_wr   = 0;
        cnt_wrst = 0;
    endtask

    task automatic model_edge();
        bit accept;
        e_write = 1'b0;
        e_wrst  = 1'b0;
        if (rst) begin
            n        = 0;
            m_active = 1'b0;
            m_count  = 0;
            m_done   = 1'b0;
            m_err    = 1'b0;
            e_wrst   = 1'b1;
        end else begin
            n++;
            accept = pix_frame_start && (wr_en || (m_active && m_count < FB_PIXELS));
            if (accept) begin
                e_wrst   = 1'b1;
                m_active = 1'b1;
                m_count  = 0;
                m_done   = 1'b0;
                if (pix_valid) m_err = 1'b1;
            end else if (pix_valid && m_active) begin
                if (m_count < FB_PIXELS) begin
                    e_write = 1'b1;
                    e_wdata = pix_data;
                    m_count++;
                    if (m_count == FB_PIXELS) m_done = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    endtask

    task automatic checkOutput();
        bit e_read, e_rptr, e_de, e_hs, e_vs;
        e_read = (n >= 1) && vis_at(n - 1);
        e_rptr = (n >= 1) ? (vpos(n - 1) >= V_VIS) : 1'b1;
        e_de   = (n >= 2) && vis_at(n - 2);
        e_hs   = (n >= 2) && (hpos(n - 2) >= H_VIS + H_FP) && (hpos(n - 2) < H_VIS + H_FP + H_SYNC);
        e_vs   = (n >= 2) && (vpos(n - 2) >= V_VIS + V_FP) && (vpos(n - 2) < V_VIS + V_FP + V_SYNC);
        check_value("fb_read", 32'(fb_read), 32'(e_read));
        check_value("rd_ptr_rst", 32'(fb_reset_read_ptr), 32'(e_rptr));
        check_value("rd_excl", 32'(fb_read & fb_reset_read_ptr), 32'd0);
        check_value("de", 32'(de), 32'(e_de));
        check_value("hsync", 32'(hsync), 32'(sync_lvl(e_hs)));
        check_value("vsync", 32'(vsync), 32'(sync_lvl(e_vs)));
        check_value("fb_write", 32'(fb_write), 32'(e_write));
        check_value("wr_ptr_rst", 32'(fb_reset_write_ptr), 32'(e_wrst));
        if (e_write) check_value("fb_wdata", 32'(fb_wdata), 32'(e_wdata));
        check_value("frame_done", 32'(frame_done), 32'(m_done));
        check_value("proto_err", 32'(proto_err), 32'(m_err));
        if (fb_read) cnt_read++;
        if (de) cnt_de++;
        if (hsync == SYNC_POL) cnt_hs++;
        if (vsync == SYNC_POL) cnt_vs++;
        if (fb_write) cnt_wr++;
        if (fb_reset_write_ptr) cnt_wrst++;
    endtask

    // Inputs are set at the falling edge; the model consumes them before the rising edge.
    task automatic applyStimulus();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic send_pixels(input int count, input int first);
        for (int i = 0; i < count; i++) begin
            repeat ($urandom_range(0, 2)) begin
                pix_valid = 1'b0;
                applyStimulus();
            end
            pix_valid = 1'b1;
            pix_data  = 4'((first + i) % 16);
            wr_en     = 1'($urandom);
            applyStimulus();
        end
        pix_valid = 1'b0;
    endtask

    initial begin
        int writes_before;
        rst             = 1'b1;
        pix_valid       = 1'b0;
        pix_data        = 4'd0;
        pix_frame_start = 1'b0;
        wr_en           = 1'b0;
        clear_counts();
        repeat (3) applyStimulus();

        // One free-running display frame with stray pixels that idle must ignore.
        rst = 1'b0;
        clear_counts();
        for (int i = 0; i < FRAME; i++) begin
            pix_valid = 1'($urandom_range(0, 1));
            pix_data  = 4'($urandom);
            applyStimulus();
        end
        pix_valid = 1'b0;
        check_value("frame_reads", 32'(cnt_read), 32'(H_VIS * V_VIS));
        check_value("frame_de", 32'(cnt_de), 32'(H_VIS * V_VIS));
        check_value("frame_hsync", 32'(cnt_hs), 32'(H_SYNC * V_TOTAL));
        check_value("frame_vsync", 32'(cnt_vs), 32'(V_SYNC * H_TOTAL));
        check_value("idle_writes", 32'(cnt_wr), 32'd0);

        // Full frame: start, one idle clock, then FB_PIXELS pixels with data i%16.
        clear_counts();
        wr_en           = 1'b1;
        pix_frame_start = 1'b1;
        applyStimulus();
        pix_frame_start = 1'b0;
        applyStimulus();
        send_pixels(FB_PIXELS, 0);
        applyStimulus();
        check_value("fill_writes", 32'(cnt_wr), 32'(FB_PIXELS));
        check_value("fill_ptr_resets", 32'(cnt_wrst), 32'd1);
        check_value("fill_done", 32'(frame_done), 32'd1);
        check_value("fill_err", 32'(proto_err), 32'd0);

        // Overrun after a full frame.
        clear_counts();
        repeat (3) begin
            pix_valid = 1'b1;
            pix_data  = 4'($urandom);
            applyStimulus();
        end
        pix_valid = 1'b0;
        applyStimulus();
        check_value("overrun_writes", 32'(cnt_wr), 32'd0);
        check_value("overrun_err", 32'(proto_err), 32'd1);
        check_value("overrun_done", 32'(frame_done), 32'd1);

        // Frozen image: frame start with wr_en low while full.
        clear_counts();
        wr_en           = 1'b0;
        pix_frame_start = 1'b1;
        applyStimulus();
        pix_frame_start = 1'b0;
        applyStimulus();
        check_value("frozen_ptr_resets", 32'(cnt_wrst), 32'd0);
        check_value("frozen_done", 32'(frame_done), 32'd1);

        // Reset, then a frame start carrying a pixel.
        rst = 1'b1;
        repeat (2) applyStimulus();
        rst = 1'b0;
        clear_counts();
        wr_en           = 1'b1;
        pix_frame_start = 1'b1;
        pix_valid       = 1'b1;
        pix_data        = 4'hA;
        applyStimulus();
        pix_frame_start = 1'b0;
        pix_valid       = 1'b0;
        applyStimulus();
        check_value("coincident_ptr_resets", 32'(cnt_wrst), 32'd1);
        check_value("coincident_writes", 32'(cnt_wr), 32'd0);
        check_value("coincident_err", 32'(proto_err), 32'd1);

        // Restart mid-fill, then reset at pixel 250 of the new frame.
        send_pixels(120, 0);
        wr_en           = 1'b1;
        pix_frame_start = 1'b1;
        applyStimulus();
        pix_frame_start = 1'b0;
        check_value("restart_done", 32'(frame_done), 32'd0);
        send_pixels(250, 3);
        writes_before = cnt_wr;
        pix_valid = 1'b1;
        rst       = 1'b1;
        applyStimulus();
        check_value("rst_write_stop", 32'(cnt_wr), 32'(writes_before));
        applyStimulus();
        rst = 1'b0;
        clear_counts();
        for (int i = 0; i < H_TOTAL; i++) begin
            pix_valid = 1'($urandom_range(0, 1));
            pix_data  = 4'($urandom);
            applyStimulus();
        end
        pix_valid = 1'b0;
        check_value("post_rst_line_reads", 32'(cnt_read), 32'(H_VIS));
        check_value("post_rst_writes", 32'(cnt_wr), 32'd0);

        // Reset at mid-raster line V_VIS/2.
        for (int k = 0; k < FRAME && vpos(n) != V_VIS / 2; k++) applyStimulus();
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        clear_counts();
        repeat (H_TOTAL) applyStimulus();
        check_value("mid_rst_line_reads", 32'(cnt_read), 32'(H_VIS));
        check_value("mid_rst_line_hsync", 32'(cnt_hs), 32'(H_SYNC));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
